// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory handshake, controller/datapath controls and decoded IR fields.
// Optional counters (FETCH_PERF_EN) add retired_cnt_o and jmp_taken_cnt_o.
interface fetch_if #(parameter int PC_W = 8);
  logic            imem_req_o;
  logic [PC_W-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [15:0]     imem_rdata_i;
  logic            stall_i;
  logic            halt_i;
  logic            en_jmp_i;
  logic            use_immediate_pc_i;
  logic            flag_carry_i;
  logic            flag_zero_i;
  logic            instr_valid_o;
  logic [3:0]      opcode_o;
  logic [1:0]      rd_o;
  logic [1:0]      rs_o;
  logic [7:0]      imm_o;
  logic [PC_W-1:0] pc_o;
  logic            halted_o;
`ifdef FETCH_PERF_EN
  logic [15:0]     retired_cnt_o;
  logic [15:0]     jmp_taken_cnt_o;
`endif

  modport master (
`ifdef FETCH_PERF_EN
    output retired_cnt_o, output jmp_taken_cnt_o,
`endif
    output imem_req_o, output imem_addr_o, input imem_ack_i, input imem_rdata_i,
    input stall_i, input halt_i, input en_jmp_i, input use_immediate_pc_i,
    input flag_carry_i, input flag_zero_i,
    output instr_valid_o, output opcode_o, output rd_o, output rs_o, output imm_o,
    output pc_o, output halted_o
  );

  modport slave (
`ifdef FETCH_PERF_EN
    input retired_cnt_o, input jmp_taken_cnt_o,
`endif
    input imem_req_o, input imem_addr_o, output imem_ack_i, output imem_rdata_i,
    output stall_i, output halt_i, output en_jmp_i, output use_immediate_pc_i,
    output flag_carry_i, output flag_zero_i,
    input instr_valid_o, input opcode_o, input rd_o, input rs_o, input imm_o,
    input pc_o, input halted_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch/PC stage: 2 cycles per instruction with zero-wait memory; request held until ack, stall_i freezes EXEC.
// Optional macro FETCH_PERF_EN adds saturating retire / taken-jump counters.
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic    clk_i,
  input logic    rst_n_i,
  fetch_if.master bus
);

  // Shared instruction-set encodings for the jump family.
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JE  = 4'h9;
  localparam logic [3:0] OP_JNE = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] ir_pc;
  logic [15:0]     ir;
  logic            req;
  logic            valid;
  logic            halted;
  logic            halt_pend;
  logic            taken;
  logic            retire;
  logic [PC_W-1:0] next_pc;
`ifdef FETCH_PERF_EN
  logic [15:0]     retired_cnt;
  logic [15:0]     jmp_cnt;
`endif

  always_comb begin
    taken = bus.en_jmp_i &&
            ((ir[15:12] == OP_JMP) ||
             (ir[15:12] == OP_JE  &&  bus.flag_zero_i) ||
             (ir[15:12] == OP_JNE && !bus.flag_zero_i) ||
             (ir[15:12] == OP_JC  &&  bus.flag_carry_i));
    retire = (state == S_EXEC) && !bus.stall_i;
    if (taken && bus.use_immediate_pc_i)
      next_pc = PC_W'(ir[7:0]);
    else if (taken)
      next_pc = ir_pc + PC_W'($signed(ir[7:0]));
    else
      next_pc = ir_pc + PC_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ir_pc     <= '0;
      ir        <= '0;
      req       <= 1'b0;
      valid     <= 1'b0;
      halted    <= 1'b0;
      halt_pend <= 1'b0;
`ifdef FETCH_PERF_EN
      retired_cnt <= '0;
      jmp_cnt     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
          req   <= 1'b1;
        end
        S_FETCH: begin
          // A halt seen mid-fetch is remembered until the instruction retires.
          if (bus.halt_i) halt_pend <= 1'b1;
          if (bus.imem_ack_i) begin
            ir    <= bus.imem_rdata_i;
            ir_pc <= pc;
            req   <= 1'b0;
            valid <= 1'b1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.halt_i) halt_pend <= 1'b1;
          if (retire) begin
            pc    <= next_pc;
            valid <= 1'b0;
            if (bus.halt_i || halt_pend) begin
              state     <= S_HALT;
              halted    <= 1'b1;
              halt_pend <= 1'b0;
            end else begin
              state <= S_FETCH;
              req   <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (!bus.halt_i) begin
            state  <= S_FETCH;
            halted <= 1'b0;
            req    <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef FETCH_PERF_EN
      if (retire && retired_cnt != 16'hFFFF) retired_cnt <= retired_cnt + 16'd1;
      if (retire && taken && jmp_cnt != 16'hFFFF) jmp_cnt <= jmp_cnt + 16'd1;
`endif
    end
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = pc;
  assign bus.instr_valid_o = valid;
  assign bus.opcode_o      = ir[15:12];
  assign bus.rd_o          = ir[11:10];
  assign bus.rs_o          = ir[9:8];
  assign bus.imm_o         = ir[7:0];
  assign bus.pc_o          = ir_pc;
  assign bus.halted_o      = halted;
`ifdef FETCH_PERF_EN
  assign bus.retired_cnt_o   = retired_cnt;
  assign bus.jmp_taken_cnt_o = jmp_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table of next-pc cases, directed multi-cycle sequences, random run against an ISA-level model.
module tb_fetch_unit;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JE  = 4'h9;
  localparam logic [3:0] OP_JNE = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;

  logic clk;
  logic rst_n;
  fetch_if #(.PC_W(8)) bus();
  fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  logic ctrl_en [256];
  logic ctrl_use [256];
  logic ctrl_z [256];
  logic ctrl_c [256];
  logic [7:0] fetch_log [$];
  time        fetch_t [$];
  int  ack_delay = 0;
  int  stall_pc = -1;
  int  stall_budget = 0;
  bit  rand_mode = 0;
  bit  model_en = 0;
  logic [7:0] exp_pc;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        en, use_imm, z, c;
    logic [7:0]  exp_next;
  } vec_t;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_next(input logic [7:0] pc, input logic [15:0] w,
                                          input logic en, input logic use_imm,
                                          input logic z, input logic c);
    logic [3:0] op;
    logic t;
    int sum;
    op = w[15:12];
    t = en && (op == OP_JMP || (op == OP_JE && z) || (op == OP_JNE && !z) || (op == OP_JC && c));
    if (!t) return pc + 8'd1;
    if (use_imm) return w[7:0];
    sum = int'(pc) + int'($signed(w[7:0]));
    return 8'(sum & 255);
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h0000;
      ctrl_en[i] = 0; ctrl_use[i] = 0; ctrl_z[i] = 0; ctrl_c[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    fetch_log.delete();
    fetch_t.delete();
    rst_n = 1;
  endtask

  // Memory responder and control driver, updated just after each rising edge.
  initial begin
    int  cnt;
    bit  busy;
    int  idx;
    busy = 0;
    cnt = 0;
    bus.imem_ack_i = 0; bus.imem_rdata_i = 0; bus.stall_i = 0; bus.halt_i = 0;
    bus.en_jmp_i = 0; bus.use_immediate_pc_i = 0; bus.flag_zero_i = 0; bus.flag_carry_i = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_ack_i = 0;
      if (!rst_n) busy = 0;
      else if (bus.imem_req_o) begin
        if (!busy) begin
          busy = 1;
          cnt = rand_mode ? int'($urandom_range(0, 3)) : ack_delay;
        end
        if (cnt == 0) begin
          bus.imem_ack_i = 1;
          bus.imem_rdata_i = mem[bus.imem_addr_o];
          busy = 0;
          fetch_log.push_back(bus.imem_addr_o);
          fetch_t.push_back($time);
        end else cnt--;
      end
      if (rand_mode) begin
        bus.stall_i = ($urandom_range(0, 3) == 0);
        bus.halt_i = ($urandom_range(0, 31) == 0);
        bus.en_jmp_i = 1'($urandom_range(0, 1));
        bus.use_immediate_pc_i = 1'($urandom_range(0, 1));
        bus.flag_zero_i = 1'($urandom_range(0, 1));
        bus.flag_carry_i = 1'($urandom_range(0, 1));
      end else begin
        idx = int'(bus.pc_o);
        bus.en_jmp_i = ctrl_en[idx];
        bus.use_immediate_pc_i = ctrl_use[idx];
        bus.flag_zero_i = ctrl_z[idx];
        bus.flag_carry_i = ctrl_c[idx];
        bus.stall_i = bus.instr_valid_o && (idx == stall_pc) && (stall_budget > 0);
        if (bus.stall_i) stall_budget--;
      end
    end
  end

  // ISA-level reference: tracks the expected instruction stream independently of the RTL.
  initial begin
    logic [15:0] w;
    forever begin
      @(negedge clk);
      if (model_en && rst_n) begin
        if (bus.imem_req_o && bus.imem_ack_i) chk("rand_fetch_addr", bus.imem_addr_o, exp_pc);
        if (bus.instr_valid_o && !bus.stall_i) begin
          w = mem[exp_pc];
          chk("rand_pc", bus.pc_o, exp_pc);
          chk("rand_ir", {bus.opcode_o, bus.rd_o, bus.rs_o, bus.imm_o}, w);
          exp_pc = ref_next(exp_pc, w, bus.en_jmp_i, bus.use_immediate_pc_i,
                            bus.flag_zero_i, bus.flag_carry_i);
        end
      end
    end
  end

  initial begin
    vec_t vecs [13];
    int req_cyc, val_cyc, k;
    bit saw;
    rst_n = 0;
    clear_prog();
    vecs[0]  = '{8'h05, {OP_JMP, 4'h0, 8'h40}, 1, 1, 0, 0, 8'h40};
    vecs[1]  = '{8'h10, {OP_JE,  4'h0, 8'hFE}, 1, 0, 1, 0, 8'h0E};
    vecs[2]  = '{8'h10, {OP_JE,  4'h0, 8'hFE}, 1, 0, 0, 0, 8'h11};
    vecs[3]  = '{8'h10, {OP_JC,  4'h0, 8'h03}, 1, 0, 0, 1, 8'h13};
    vecs[4]  = '{8'h10, {OP_JC,  4'h0, 8'h03}, 1, 0, 1, 0, 8'h11};
    vecs[5]  = '{8'h10, {OP_JNE, 4'h0, 8'h02}, 1, 0, 0, 0, 8'h12};
    vecs[6]  = '{8'h10, {OP_JNE, 4'h0, 8'h02}, 1, 0, 1, 0, 8'h11};
    vecs[7]  = '{8'h20, {OP_JMP, 4'h0, 8'hF0}, 1, 0, 0, 0, 8'h10};
    vecs[8]  = '{8'h30, {OP_JMP, 4'h0, 8'h40}, 0, 1, 0, 0, 8'h31};
    vecs[9]  = '{8'h40, {4'h3,   4'h5, 8'h05}, 1, 1, 1, 1, 8'h41};
    vecs[10] = '{8'hFF, {4'h1,   4'h0, 8'h00}, 0, 0, 0, 0, 8'h00};
    vecs[11] = '{8'h50, {OP_JE,  4'h0, 8'h07}, 1, 1, 1, 0, 8'h07};
    vecs[12] = '{8'hF0, {OP_JMP, 4'h0, 8'h20}, 1, 0, 0, 0, 8'h10};

    // Reset state and zero-wait throughput over straight-line code.
    repeat (2) @(negedge clk);
    chk("rst_req", bus.imem_req_o, 0);
    chk("rst_outs", {bus.instr_valid_o, bus.halted_o, bus.opcode_o, bus.rd_o, bus.rs_o,
                     bus.imm_o, bus.pc_o, bus.imem_addr_o}, 0);
`ifdef FETCH_PERF_EN
    chk("rst_cnt", {bus.retired_cnt_o, bus.jmp_taken_cnt_o}, 0);
`endif
    for (int i = 0; i < 4; i++) mem[i] = {4'h1, 4'h0, 8'(i + 8'h10)};
    rst_n = 1;
    #1 chk("first_cycle_req", bus.imem_req_o, 0);
    @(posedge clk);
    #2 chk("second_cycle_req", bus.imem_req_o, 1);
    for (k = 0; k < 40 && fetch_log.size() < 5; k++) @(negedge clk);
    chk("seq_timeout", fetch_log.size() >= 5, 1);
    if (fetch_log.size() >= 5)
      for (int i = 0; i < 4; i++) begin
        chk("seq_addr", fetch_log[i], i);
        chk("seq_period", 32'(fetch_t[i+1] - fetch_t[i]), 20);
      end

    // Next-pc vectors: a setup JMP at 0 lands on the vector's pc.
    foreach (vecs[v]) begin
      clear_prog();
      mem[0] = {OP_JMP, 4'h0, vecs[v].pc};
      ctrl_en[0] = 1; ctrl_use[0] = 1;
      mem[vecs[v].pc] = vecs[v].instr;
      ctrl_en[vecs[v].pc] = vecs[v].en; ctrl_use[vecs[v].pc] = vecs[v].use_imm;
      ctrl_z[vecs[v].pc] = vecs[v].z; ctrl_c[vecs[v].pc] = vecs[v].c;
      do_reset();
      for (k = 0; k < 40 && fetch_log.size() < 3; k++) @(negedge clk);
      chk("vec_timeout", fetch_log.size() >= 3, 1);
      if (fetch_log.size() >= 3) chk($sformatf("vec%0d_next", v), fetch_log[2], vecs[v].exp_next);
    end

    // Ack delayed by 3 cycles, then 4 stall cycles: everything frozen, one advance.
    clear_prog();
    mem[0] = 16'h1234;
    ack_delay = 3; stall_pc = 0; stall_budget = 4;
    do_reset();
    req_cyc = 0; val_cyc = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (val_cyc > 0 && !bus.instr_valid_o) break;
      if (bus.imem_req_o) begin
        req_cyc++;
        chk("delay_addr_hold", bus.imem_addr_o, 0);
      end
      if (bus.instr_valid_o) begin
        val_cyc++;
        chk("stall_ir_hold", {bus.opcode_o, bus.rd_o, bus.rs_o, bus.imm_o}, 16'h1234);
        chk("stall_pc_hold", bus.pc_o, 0);
      end
    end
    chk("delay_req_cycles", req_cyc, 4);
    chk("stall_exec_cycles", val_cyc, 5);
    for (k = 0; k < 20 && fetch_log.size() < 2; k++) @(negedge clk);
    chk("stall_next_fetch", fetch_log.size() >= 2 ? 32'(fetch_log[1]) : 32'hDEAD, 1);

    // Halt raised during FETCH and held: retire, park, then resume at the held pc.
    clear_prog();
    ack_delay = 2; stall_pc = -1; stall_budget = 0;
    do_reset();
    for (k = 0; k < 10 && !bus.imem_req_o; k++) @(negedge clk);
    bus.halt_i = 1;
    for (k = 0; k < 20 && !bus.halted_o; k++) @(negedge clk);
    chk("halt_entered", bus.halted_o, 1);
    chk("halt_retired_one", fetch_log.size(), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_no_req", {bus.imem_req_o, bus.instr_valid_o, bus.halted_o}, 3'b001);
    end
    bus.halt_i = 0;
    for (k = 0; k < 20 && fetch_log.size() < 2; k++) @(negedge clk);
    chk("halt_resume_addr", fetch_log.size() >= 2 ? 32'(fetch_log[1]) : 32'hDEAD, 1);
    chk("halt_released", bus.halted_o, 0);

    // One-cycle halt pulse during FETCH must still park the unit after retire.
    do_reset();
    for (k = 0; k < 10 && !bus.imem_req_o; k++) @(negedge clk);
    bus.halt_i = 1;
    @(negedge clk);
    bus.halt_i = 0;
    saw = 0;
    for (k = 0; k < 20 && !saw; k++) begin
      @(negedge clk);
      if (bus.halted_o) saw = 1;
    end
    chk("halt_pulse_parks", saw, 1);

    // Reset asserted while stalled: outputs clear at once, fetch restarts at RESET_PC.
    clear_prog();
    ack_delay = 0;
    mem[0] = {OP_JMP, 4'h0, 8'h20};
    ctrl_en[0] = 1; ctrl_use[0] = 1;
    mem[8'h20] = 16'h1ABC;
    stall_pc = 8'h20; stall_budget = 100;
    do_reset();
    for (k = 0; k < 30 && !(bus.instr_valid_o && bus.pc_o == 8'h20); k++) @(negedge clk);
    chk("midstall_reached", bus.instr_valid_o && bus.pc_o == 8'h20, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("midstall_rst_outs", {bus.imem_req_o, bus.instr_valid_o, bus.halted_o, bus.opcode_o,
                                 bus.imm_o, bus.pc_o, bus.imem_addr_o}, 0);
    stall_budget = 0; stall_pc = -1;
    do_reset();
    for (k = 0; k < 20 && fetch_log.size() < 1; k++) @(negedge clk);
    chk("midstall_restart", fetch_log.size() >= 1 ? 32'(fetch_log[0]) : 32'hDEAD, 0);

`ifdef FETCH_PERF_EN
    // Ten retires, three of them taken jumps; the eleventh instruction stalls.
    clear_prog();
    mem[0] = {OP_JMP, 4'h0, 8'h02}; ctrl_en[0] = 1; ctrl_use[0] = 1;
    mem[3] = {OP_JE, 4'h0, 8'h02};  ctrl_en[3] = 1; ctrl_z[3] = 1;
    mem[7] = {OP_JC, 4'h0, 8'h02};  ctrl_en[7] = 1; ctrl_c[7] = 1;
    stall_pc = 13; stall_budget = 1000;
    do_reset();
    for (k = 0; k < 100 && !(bus.instr_valid_o && bus.pc_o == 8'd13); k++) @(negedge clk);
    chk("perf_retired", bus.retired_cnt_o, 10);
    chk("perf_taken", bus.jmp_taken_cnt_o, 3);
    stall_pc = -1; stall_budget = 0;
`endif

    // Random program and random controls against the ISA-level model.
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rand_mode = 1;
    rst_n = 0;
    repeat (2) @(negedge clk);
    exp_pc = 8'h00;
    model_en = 1;
    rst_n = 1;
    repeat (3000) @(negedge clk);
    model_en = 0;
    rand_mode = 0;
    bus.halt_i = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
